// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: controller state encoding,
// default widths and the carry-save helper used by the multiplier tree.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mac_state_t;

  localparam int MAC_W     = 8;
  localparam int MAC_ACC_W = 24;
  localparam int MAC_LEN_W = 8;

  // 3:2 compressor on 16-bit words; returns {carry (already weighted), sum}.
  function automatic logic [31:0] csa16(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic [15:0] z);
    logic [15:0] s;
    logic [15:0] c;
    s = x ^ y ^ z;
    c = (x & y) | (x & z) | (y & z);
    return {(c << 4'd1), s};
  endfunction

endpackage

// File: rtl/wm.sv
// Combinational 8x8 unsigned Wallace-tree multiplier. Partial products are
// reduced by layers of 3:2 compressors down to two rows, which a final
// carry-propagate adder sums. The carry out of that adder is always zero for
// an 8x8 product but is exposed for callers that want it.
module wm
  import mac_pkg::*;
(
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p,
  output logic        cout
);

  logic [15:0] pp [8];
  logic [31:0] t0, t1, t2, t3, t4, t5;

  // Build shifted partial products, one per multiplier bit.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = b[i] ? (16'(a) << i) : 16'd0;
    end
  end

  // Reduction tree: 8 rows -> 6 -> 4 -> 3 -> 2.
  assign t0 = csa16(pp[0], pp[1], pp[2]);
  assign t1 = csa16(pp[3], pp[4], pp[5]);
  assign t2 = csa16(t0[15:0], t0[31:16], t1[15:0]);
  assign t3 = csa16(t1[31:16], pp[6], pp[7]);
  assign t4 = csa16(t2[15:0], t2[31:16], t3[15:0]);
  assign t5 = csa16(t4[15:0], t4[31:16], t3[31:16]);

  assign {cout, p} = {1'b0, t5[15:0]} + {1'b0, t5[31:16]};

endmodule

// File: rtl/mac_seq.sv
// Dot-product sequencer: accepts len operand pairs over a valid/ready
// handshake, multiplies each through the shared wm instance, registers the
// product, accumulates it one edge later and returns the sum on an output
// handshake. Overflow is sticky for the duration of a job.
module mac_seq
  import mac_pkg::*;
#(
  parameter int W     = MAC_W,
  parameter int ACC_W = MAC_ACC_W,
  parameter int LEN_W = MAC_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             overflow
);

  mac_state_t       state;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_inc;
  logic [2*W-1:0]   p_reg;
  logic             p_vld;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum_ext;
  logic [2*W-1:0]   prod;
  logic             cout_unused;
  logic             accept;
  logic             acc_en;

  // The multiplier's carry out is always zero for a W x W product.
  wm u_wm (
    .a    (a),
    .b    (b),
    .p    (prod),
    .cout (cout_unused)
  );

  assign accept  = in_valid & in_ready & (state == LOAD);
  assign acc_en  = p_vld & ((state == LOAD) | (state == DRAIN));
  assign cnt_inc = cnt + {{(LEN_W-1){1'b0}}, 1'b1};
  assign sum_ext = {1'b0, acc} + {{(ACC_W+1-2*W){1'b0}}, p_reg};

  // Controller FSM, product pipeline stage, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_r     <= {LEN_W{1'b0}};
      cnt       <= {LEN_W{1'b0}};
      p_reg     <= {(2*W){1'b0}};
      p_vld     <= 1'b0;
      acc       <= {ACC_W{1'b0}};
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= {ACC_W{1'b0}};
      overflow  <= 1'b0;
    end else begin
      // Product registered on the previous edge is summed on this one.
      if (acc_en) begin
        acc <= sum_ext[ACC_W-1:0];
        if (sum_ext[ACC_W]) begin
          overflow <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            acc      <= {ACC_W{1'b0}};
            overflow <= 1'b0;
            cnt      <= {LEN_W{1'b0}};
            p_vld    <= 1'b0;
            if (len != {LEN_W{1'b0}}) begin
              len_r    <= len;
              in_ready <= 1'b1;
              state    <= LOAD;
            end else begin
              result    <= {ACC_W{1'b0}};
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            p_reg <= prod;
            p_vld <= 1'b1;
            cnt   <= cnt_inc;
            if (cnt_inc == len_r) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end else begin
            p_vld <= 1'b0;
          end
        end
        DRAIN: begin
          p_vld     <= 1'b0;
          result    <= acc_en ? sum_ext[ACC_W-1:0] : acc;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= {ACC_W{1'b0}};
            overflow  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          p_vld     <= 1'b0;
          result    <= {ACC_W{1'b0}};
          overflow  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: a 24-bit and a 16-bit accumulator instance share all
// inputs. The reference is the plain dot product of the pairs fed in,
// reduced modulo 2^ACC_W; overflow is expected when that sum reaches 2^ACC_W.
module tb_mac_seq;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [7:0]  len, a, b;
  logic        busy_w, in_ready_w, out_valid_w, overflow_w;
  logic [23:0] result_w;
  logic        busy_n, in_ready_n, out_valid_n, overflow_n;
  logic [15:0] result_n;

  int compared   = 0;
  int mismatched = 0;
  int job_id     = 0;
  int pa [256];
  int pb [256];

  always #5 clk = ~clk;

  mac_seq #(.W(8), .ACC_W(24), .LEN_W(8)) dut_w (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy_w),
    .in_valid(in_valid), .in_ready(in_ready_w), .a(a), .b(b),
    .out_valid(out_valid_w), .out_ready(out_ready), .result(result_w),
    .overflow(overflow_w)
  );

  mac_seq #(.W(8), .ACC_W(16), .LEN_W(8)) dut_n (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy_n),
    .in_valid(in_valid), .in_ready(in_ready_n), .a(a), .b(b),
    .out_valid(out_valid_n), .out_ready(out_ready), .result(result_n),
    .overflow(overflow_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // All outputs of both instances at their reset / IDLE values.
  task automatic check_idle(input string tag);
    check({tag, ":ctl"}, {24'd0, busy_w, in_ready_w, out_valid_w, overflow_w,
                          busy_n, in_ready_n, out_valid_n, overflow_n}, 32'd0);
    check({tag, ":res_w"}, {8'd0, result_w}, 32'd0);
    check({tag, ":res_n"}, {16'd0, result_n}, 32'd0);
  endtask

  // One complete job using pa/pb[0..n-1].
  task automatic run_job(input int n, input int gap_lo, input int gap_hi,
                         input int hold, input bit poke);
    longint total;
    int     gap;
    string  t;
    total = 0;
    for (int i = 0; i < n; i++) total += longint'(pa[i]) * longint'(pb[i]);
    job_id++;
    t = $sformatf("job%0d", job_id);
    check_idle({t, ":pre"});
    start = 1'b1;
    len   = 8'(n);
    step();
    start = 1'b0;
    len   = 8'($urandom);
    check({t, ":busy"}, {30'd0, busy_w, busy_n}, 32'd3);
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(gap_hi, gap_lo);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        check({t, ":gap_rdy"}, {30'd0, in_ready_w, in_ready_n}, 32'd3);
        step();
      end
      in_valid = 1'b1;
      a = 8'(pa[i]);
      b = 8'(pb[i]);
      check({t, ":rdy"}, {30'd0, in_ready_w, in_ready_n}, 32'd3);
      check({t, ":early_ov"}, {30'd0, out_valid_w, out_valid_n}, 32'd0);
      step();
    end
    if (n != 0) begin
      in_valid = 1'b1;
      a = 8'($urandom);
      b = 8'($urandom);
      check({t, ":drain_rdy"}, {30'd0, in_ready_w, in_ready_n}, 32'd0);
      check({t, ":drain_ov"}, {30'd0, out_valid_w, out_valid_n}, 32'd0);
      step();
      in_valid = 1'b0;
    end
    for (int k = 0; k <= hold; k++) begin
      out_ready = (k == hold);
      if (poke) begin
        start = 1'b1;
        len   = 8'($urandom_range(255, 1));
      end
      check({t, ":done_ctl"}, {26'd0, out_valid_w, out_valid_n, busy_w, busy_n,
                               in_ready_w, in_ready_n}, 32'd60);
      check({t, ":res_w"}, {8'd0, result_w}, 32'(total % 64'd16777216));
      check({t, ":ovf_w"}, {31'd0, overflow_w}, {31'd0, total >= 64'd16777216});
      check({t, ":res_n"}, {16'd0, result_n}, 32'(total % 64'd65536));
      check({t, ":ovf_n"}, {31'd0, overflow_n}, {31'd0, total >= 64'd65536});
      step();
    end
    start     = 1'b0;
    out_ready = 1'b0;
    check_idle({t, ":post"});
    step();
    check_idle({t, ":noqueue"});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    len = 8'd0; a = 8'd0; b = 8'd0;
    step();
    step();
    check_idle("reset");
    rst = 1'b0;
    step();
    check_idle("after_reset");

    // Single pair.
    pa[0] = 211; pb[0] = 206;
    run_job(1, 0, 0, 0, 1'b0);

    // Three back-to-back maximal pairs.
    for (int i = 0; i < 3; i++) begin pa[i] = 255; pb[i] = 255; end
    run_job(3, 0, 0, 0, 1'b0);

    // Empty job.
    run_job(0, 0, 0, 0, 1'b0);
    run_job(0, 0, 0, 2, 1'b1);

    // Two maximal pairs: wraps the 16-bit accumulator.
    for (int i = 0; i < 2; i++) begin pa[i] = 255; pb[i] = 255; end
    run_job(2, 0, 0, 1, 1'b0);

    // Backpressure on both sides with a start pulse during DONE.
    pa[0] = 1; pb[0] = 2; pa[1] = 3; pb[1] = 4;
    pa[2] = 5; pb[2] = 6; pa[3] = 7; pb[3] = 8;
    run_job(4, 2, 2, 5, 1'b1);

    // Reset after two of four pairs, then a fresh job.
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = 8'd200; b = 8'd250;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    check_idle("mid_rst");
    rst = 1'b0;
    pa[0] = 3; pb[0] = 4;
    run_job(1, 0, 0, 0, 1'b0);

    // Randomised jobs.
    for (int j = 0; j < 10; j++) begin
      int n;
      n = $urandom_range(6, 1);
      for (int i = 0; i < n; i++) begin
        pa[i] = $urandom_range(255, 0);
        pb[i] = $urandom_range(255, 0);
      end
      run_job(n, 0, 2, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    // Longest possible job with maximal operands.
    for (int i = 0; i < 255; i++) begin pa[i] = 255; pb[i] = 255; end
    run_job(255, 0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
# mac_seq

Sequencing controller for the MAC datapath. It accepts a dot-product job of `len` operand pairs and streams them through one shared instance of the combinational 8x8 Wallace multiplier `wm` with a valid/ready handshake. Products are registered, summed into a wide accumulator, and the final sum is returned on an output handshake. It sits between the operand source (memory/FIFO) and the result consumer, and is the only user of `wm` in the MAC path.

## Interface
- `W`, 8, operand width; fixed by `wm`, and the product is 2*W bits.
- `ACC_W`, 24, accumulator/result width; must be ≥ 2*W.
- `LEN_W`, 8, width of the job length; maximum job is 2^LEN_W−1 pairs.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a job; sampled only in IDLE.
- `len`  in  LEN_W  pair count; captured when `start` is accepted.
- `busy`  out  1  high in any state other than IDLE.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  controller accepts a pair.
- `a`, `b`  in  W each  unsigned operands.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  ACC_W  accumulated sum, modulo 2^ACC_W.
- `overflow`  out  1  sticky per job; set if any accumulate carried out of ACC_W.

## Operation
- States: IDLE, LOAD, DRAIN, DONE. `rst` forces IDLE from any state.
- Reset values and IDLE values: `busy`=0, `in_ready`=0, `out_valid`=0, `result`=0, `overflow`=0, pair count=0, `p_vld`=0.
- IDLE:
  - `start`=1 and `len`≠0: latch `len`, clear acc/overflow/count, go to LOAD.
  - `start`=1 and `len`=0: clear acc/overflow, go directly to DONE.
- LOAD:
  - `in_ready`=1 while count < len.
  - On accept (`in_valid`&`in_ready`): `p_reg` ← `wm(a,b)` product (2W bits; `Cout` of `wm` ignored), `p_vld` ← 1, count++.
  - No accept: `p_vld` ← 0.
  - When count reaches len on an accept edge, go to DRAIN; `in_ready`=0 from the next cycle.
- Every edge in LOAD and DRAIN with `p_vld`=1: acc ← acc + zero-extended `p_reg`. A carry out of bit ACC_W−1 sets `overflow`.
- DRAIN: lasts one cycle. It performs the final accumulate, clears `p_vld`, and goes to DONE.
- DONE:
  - `out_valid`=1; `result`=acc and is held stable while `out_ready`=0.
  - On `out_valid`&`out_ready`, go to IDLE.
  - `start` in DONE, including the handshake cycle, is ignored. No queuing.
- Unsigned arithmetic only.
- `len` changes after capture have no effect.
- `in_valid` outside LOAD is ignored. `a`/`b` are don't-care when not accepted.

## Timing
- Accept-to-accumulate latency is 2 edges: the product is registered at the accept edge and summed at the next edge.
- Throughput is one pair per cycle under continuous `in_valid`.
- `out_valid` rises in the cycle after the DRAIN edge, i.e. 2 cycles after the last accept edge.
- Job with `len`=0: `out_valid`=1 in the cycle after the `start` edge, with `result`=0.
- Minimum job turnaround is len+3 cycles, assuming no stalls.
- `in_valid` gaps stall the count. A bubble in `p_vld` does not change acc.
- `rst` mid-operation aborts the job: the in-flight product and acc are discarded and all outputs return to their reset values on that edge.

## Structure
- Shared package `mac_pkg` holds:
  - state encoding `mac_state_t` (IDLE/LOAD/DRAIN/DONE);
  - default constants `MAC_W`=8, `MAC_ACC_W`=24, `MAC_LEN_W`=8.
- Single sub-module: the existing `wm` multiplier, instantiated once with its 16-bit product feeding `p_reg`.
- Product register, accumulator, counter and FSM live in `mac_seq`; no further hierarchy.

## Test plan
- `len`=1, pair (211,206) → `result`=43466, `overflow`=0, `out_valid` 2 cycles after the accept edge.
- `len`=3, three back-to-back pairs (255,255) → `in_ready` high exactly 3 cycles, `result`=195075, `overflow`=0.
- `len`=0 → `out_valid` 1 cycle after `start`, `result`=0, `in_ready` never high.
- `ACC_W`=16 instance, `len`=2, pairs (255,255)×2 → `result`=64514, `overflow`=1.
- Backpressure case, `len`=4 with pairs (1,2),(3,4),(5,6),(7,8):
  - insert 2-cycle `in_valid` gaps;
  - hold `out_ready`=0 for 5 cycles and pulse `start` during DONE;
  - expect `result`=100 held stable and the `start` pulse ignored.
- `rst` asserted after 2 of 4 pairs → all outputs at reset values next cycle; a new job with `len`=1, pair (3,4) → `result`=12.
